// File: rtl/mem_axi_lsu.sv
// MEM-stage load/store unit: turns one EX/MEM access into a single-beat AXI4
// transaction and stalls the pipeline until that transaction completes.
module mem_axi_lsu #(
   parameter int               ID_W      = 4,
   parameter logic [ID_W-1:0]  MASTER_ID = ID_W'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [31:0]      addr,
   input  logic [31:0]      store_data,
   input  logic [2:0]       funct3,
   output logic             stall,
   output logic [31:0]      DM_read_data_reg,
   output logic             access_err,
   output logic             bus_err,
   output logic [ID_W-1:0]  ARID,
   output logic [31:0]      ARADDR,
   output logic [3:0]       ARLEN,
   output logic [2:0]       ARSIZE,
   output logic [1:0]       ARBURST,
   output logic             ARVALID,
   input  logic             ARREADY,
   input  logic [ID_W-1:0]  RID,
   input  logic [31:0]      RDATA,
   input  logic [1:0]       RRESP,
   input  logic             RLAST,
   input  logic             RVALID,
   output logic             RREADY,
   output logic [ID_W-1:0]  AWID,
   output logic [31:0]      AWADDR,
   output logic [3:0]       AWLEN,
   output logic [2:0]       AWSIZE,
   output logic [1:0]       AWBURST,
   output logic             AWVALID,
   input  logic             AWREADY,
   output logic [31:0]      WDATA,
   output logic [3:0]       WSTRB,
   output logic             WLAST,
   output logic             WVALID,
   input  logic             WREADY,
   input  logic [ID_W-1:0]  BID,
   input  logic [1:0]       BRESP,
   input  logic             BVALID,
   output logic             BREADY
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_ADDR = 3'd1;
   localparam logic [2:0] RD_DATA = 3'd2;
   localparam logic [2:0] WR_REQ  = 3'd3;
   localparam logic [2:0] WR_RESP = 3'd4;

   logic [2:0]  state, state_nxt;
   logic [31:0] bus_addr, wdata_q, wdata_nxt;
   logic [3:0]  wstrb_q, wstrb_nxt;
   logic        aw_done, w_done, aw_done_nxt, w_done_nxt;
   logic        req, misaligned, aligned_req, accept;
   logic        rd_hs, b_hs, aw_hs, w_hs;

   // Transaction IDs and the last flags carry no information with one transaction in flight.
   logic unused_inputs;
   assign unused_inputs = ^{RID, RLAST, BID, funct3[2]};

   assign ARID    = MASTER_ID;
   assign AWID    = MASTER_ID;
   assign ARLEN   = 4'd0;
   assign AWLEN   = 4'd0;
   assign ARSIZE  = 3'b010;
   assign AWSIZE  = 3'b010;
   assign ARBURST = 2'b01;
   assign AWBURST = 2'b01;
   assign WLAST   = 1'b1;
   assign ARADDR  = bus_addr;
   assign AWADDR  = bus_addr;
   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;

   // Handshake outputs decode straight from state so reset clears them immediately.
   assign ARVALID = (state == RD_ADDR);
   assign RREADY  = (state == RD_DATA);
   assign AWVALID = (state == WR_REQ) && !aw_done;
   assign WVALID  = (state == WR_REQ) && !w_done;
   assign BREADY  = (state == WR_RESP);

   assign rd_hs       = RVALID && RREADY;
   assign b_hs        = BVALID && BREADY;
   assign aw_hs       = AWVALID && AWREADY;
   assign w_hs        = WVALID && WREADY;
   assign aw_done_nxt = aw_done || aw_hs;
   assign w_done_nxt  = w_done || w_hs;

   assign req         = mem_read || mem_write;
   assign aligned_req = req && !misaligned;
   assign accept      = (state == IDLE) && aligned_req;
   assign stall       = accept || ((state != IDLE) && !rd_hs && !b_hs);

   // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      misaligned = 1'b0;
      wstrb_nxt  = 4'b1111;
      wdata_nxt  = store_data;
      case (funct3[1:0])
         2'b00: begin
            wstrb_nxt = 4'b0001 << addr[1:0];
            wdata_nxt = {4{store_data[7:0]}};
         end
         2'b01: begin
            misaligned = addr[0];
            wstrb_nxt  = 4'b0011 << {addr[1], 1'b0};
            wdata_nxt  = {2{store_data[15:0]}};
         end
         2'b10:   misaligned = (addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (aligned_req) state_nxt = mem_write ? WR_REQ : RD_ADDR;
         RD_ADDR: if (ARREADY) state_nxt = RD_DATA;
         RD_DATA: if (rd_hs) state_nxt = IDLE;
         WR_REQ:  if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
         WR_RESP: if (b_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         bus_addr         <= '0;
         wdata_q          <= '0;
         wstrb_q          <= '0;
         aw_done          <= 1'b0;
         w_done           <= 1'b0;
         DM_read_data_reg <= '0;
         access_err       <= 1'b0;
         bus_err          <= 1'b0;
      end else begin
         state      <= state_nxt;
         access_err <= (state == IDLE) && req && misaligned;
         bus_err    <= (rd_hs && (RRESP != 2'b00)) || (b_hs && (BRESP != 2'b00));
         if (rd_hs) DM_read_data_reg <= RDATA;
         if (accept) begin
            bus_addr <= {addr[31:2], 2'b00};
            wdata_q  <= wdata_nxt;
            wstrb_q  <= wstrb_nxt;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
         end else if (state == WR_REQ) begin
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
         end
      end
   end

endmodule

// File: doc/mem_axi_lsu.md
Name: mem_axi_lsu

Overview:
Load/store bus unit for the MEM stage of the 5-stage RISC-V core.
- Takes the EX/MEM access request (address, store data, funct3, read/write control).
- Runs a single-beat AXI4 transaction on the data-memory master port and stalls the pipeline until the transaction completes.
- Registers the raw read word as DM_read_data_reg, which is consumed by the MEM-stage load sign-extension logic.

Parameters:
ID_W, 4, width of AXI ARID/AWID.
MASTER_ID, 4'd1, constant ID driven on ARID/AWID.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
mem_read  in  1  load request from EX/MEM (MEM_control[1])
mem_write  in  1  store request from EX/MEM (MEM_control[0])
addr  in  32  effective address (ALU_out)
store_data  in  32  rs2 value, unaligned
funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
stall  out  1  freeze IF..MEM and hold EX/MEM
DM_read_data_reg  out  32  last read word, word-aligned raw data
access_err  out  1  one-cycle pulse: misaligned access, no bus traffic
bus_err  out  1  one-cycle pulse: RRESP/BRESP != OKAY
ARID ARADDR ARLEN ARSIZE ARBURST ARVALID  out  ID_W/32/4/3/2/1  read address channel
ARREADY  in  1
RID RDATA RRESP RLAST RVALID  in  ID_W/32/2/1/1
RREADY  out  1
AWID AWADDR AWLEN AWSIZE AWBURST AWVALID  out  ID_W/32/4/3/2/1  write address channel
AWREADY  in  1
WDATA WSTRB WLAST WVALID  out  32/4/1/1
WREADY  in  1
BID BRESP BVALID  in  ID_W/2/1
BREADY  out  1

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; all VALID/READY outputs 0.
  - DM_read_data_reg = 0; stall = 0; access_err = 0; bus_err = 0.
  - Reset mid-transaction abandons it; no completion is reported.
- Constant bus fields: ARLEN/AWLEN = 0, ARSIZE/AWSIZE = 3'b010, ARBURST/AWBURST = INCR, WLAST = 1.
- Bus address: ARADDR/AWADDR = {addr[31:2], 2'b00}, registered at acceptance.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - mem_write=1 takes priority over mem_read; both set is treated as a store.
  - Misaligned request: H/HU with addr[0]=1, or W with addr[1:0]!=0.
    - access_err pulses next cycle; no transaction; stall stays 0; state stays IDLE.
  - Aligned read: stall=1 combinationally this cycle; next state RD_ADDR with ARVALID=1.
  - Aligned write: stall=1; next state WR_REQ with AWVALID=1 and WVALID=1.
- RD_ADDR: hold ARVALID/ARADDR until ARREADY; then go to RD_DATA with RREADY=1.
- RD_DATA:
  - On RVALID&RREADY: DM_read_data_reg <= RDATA; bus_err <= (RRESP!=0).
  - stall=0 in this same cycle so the pipeline advances at the edge; next state IDLE.
- WR_REQ:
  - AW and W are independent; each VALID drops after its own handshake.
  - Handshakes may occur in either order or the same cycle (tracked by two done flags).
  - When both are done, go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID&BREADY: bus_err <= (BRESP!=0); stall=0 this cycle; next state IDLE.
- Stall rule: stall = (IDLE & aligned request) | (state!=IDLE & !completing_handshake).
- Store strobes and data, registered at acceptance:
  - SB: WSTRB = 4'b0001 << addr[1:0]; WDATA = {4{store_data[7:0]}}.
  - SH: WSTRB = 4'b0011 << {addr[1],1'b0}; WDATA = {2{store_data[15:0]}}.
  - SW: WSTRB = 4'b1111; WDATA = store_data.
- Inputs are held stable by the pipeline while stall=1; the block still uses its own registered copies.
- RID/BID are ignored (single outstanding transaction). The unit never has more than one transaction in flight.
- DM_read_data_reg is unchanged by stores, misaligned accesses and idle cycles.

Test Plan:
- LW addr 0x0000_1004, ARREADY after 2 cycles, RVALID 3 cycles later with 0xDEADBEEF -> ARADDR 0x1004, ARSIZE 2, stall high from request cycle until RVALID cycle, DM_read_data_reg=0xDEADBEEF next edge, bus_err 0.
- SB addr 0x2003, store_data 0x000000A5 -> WSTRB 4'b1000, WDATA 0xA5A5A5A5, AWADDR 0x2000; WREADY before AWREADY, then BVALID -> stall drops in BVALID cycle.
- SH addr 0x2002, store_data 0x1234BEEF, AWREADY/WREADY same cycle -> WSTRB 4'b1100, WDATA 0xBEEFBEEF, single WR_RESP wait.
- LH addr 0x3001 -> access_err pulse 1 cycle, ARVALID never asserted, stall 0, DM_read_data_reg unchanged.
- LW with RRESP=2'b10, RDATA 0x55 -> DM_read_data_reg=0x55, bus_err pulses once, state back to IDLE.
- Assert rst low while in RD_DATA with ARVALID done -> all VALID/READY 0 immediately, stall 0, DM_read_data_reg 0; after release, a new LW completes normally.
